// File: rtl/run_detect.sv
// Serial run detector: pulses detect when RUN_LEN consecutive equal valid bits arrive,
// with value filtering, optional overlap, synchronous clear and a saturating hit counter.
module run_detect #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8,
    localparam int RL_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inbits,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic             overlap,
    input  logic             clear,
    output logic             detect,
    output logic             detect_val,
    output logic [RL_W-1:0]  run_len,
    output logic [CNT_W-1:0] det_count
);

    localparam logic [RL_W-1:0]  RUN_MAX = RL_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             last_bit_q,   last_bit_d;
    logic             have_last_q,  have_last_d;
    logic [RL_W-1:0]  run_cnt_q,    run_cnt_d;
    logic             detect_q,     detect_d;
    logic             detect_val_q, detect_val_d;
    logic [CNT_W-1:0] det_count_q,  det_count_d;

    logic             cont;
    logic [RL_W-1:0]  nxt;
    logic             mode_ok;
    logic             hit;

    always_comb begin
        cont = have_last_q && (inbits == last_bit_q);
        nxt  = 1;
        if (cont) begin
            nxt = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + 1'b1;
        end

        case (mode)
            2'b00:   mode_ok = 1'b1;
            2'b01:   mode_ok = inbits;
            2'b10:   mode_ok = ~inbits;
            default: mode_ok = 1'b0;
        endcase

        hit = (nxt == RUN_MAX) && mode_ok;
    end

    always_comb begin
        last_bit_d   = last_bit_q;
        have_last_d  = have_last_q;
        run_cnt_d    = run_cnt_q;
        detect_d     = 1'b0;
        detect_val_d = detect_val_q;
        det_count_d  = det_count_q;

        if (clear) begin
            // A sample arriving alongside clear is deliberately dropped.
            run_cnt_d   = '0;
            have_last_d = 1'b0;
            det_count_d = '0;
        end else if (in_valid) begin
            last_bit_d  = inbits;
            have_last_d = 1'b1;
            run_cnt_d   = (hit && !overlap) ? '0 : nxt;
            detect_d    = hit;
            if (hit) begin
                detect_val_d = inbits;
                if (det_count_q != CNT_MAX) begin
                    det_count_d = det_count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_bit_q   <= 1'b0;
            have_last_q  <= 1'b0;
            run_cnt_q    <= '0;
            detect_q     <= 1'b0;
            detect_val_q <= 1'b0;
            det_count_q  <= '0;
        end else begin
            last_bit_q   <= last_bit_d;
            have_last_q  <= have_last_d;
            run_cnt_q    <= run_cnt_d;
            detect_q     <= detect_d;
            detect_val_q <= detect_val_d;
            det_count_q  <= det_count_d;
        end
    end

    assign detect     = detect_q;
    assign detect_val = detect_val_q;
    assign run_len    = run_cnt_q;
    assign det_count  = det_count_q;

endmodule

// File: tb/tb_run_detect.sv
// Directed bench for run_detect: three instances (RUN_LEN=2, RUN_LEN=3, RUN_LEN=2 with a 2-bit counter)
// share one stimulus stream; each phase checks the instance it targets.
module tb_run_detect;

    logic       clk;
    logic       reset;
    logic       inbits;
    logic       in_valid;
    logic [1:0] mode;
    logic       overlap;
    logic       clear;

    logic       a_det, a_val;
    logic [1:0] a_len;
    logic [7:0] a_cnt;
    logic       b_det, b_val;
    logic [1:0] b_len;
    logic [7:0] b_cnt;
    logic       c_det, c_val;
    logic [1:0] c_len;
    logic [1:0] c_cnt;

    int errors = 0;
    int checks = 0;

    run_detect #(.RUN_LEN(2), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .inbits(inbits), .in_valid(in_valid), .mode(mode),
        .overlap(overlap), .clear(clear), .detect(a_det), .detect_val(a_val),
        .run_len(a_len), .det_count(a_cnt)
    );

    run_detect #(.RUN_LEN(3), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .inbits(inbits), .in_valid(in_valid), .mode(mode),
        .overlap(overlap), .clear(clear), .detect(b_det), .detect_val(b_val),
        .run_len(b_len), .det_count(b_cnt)
    );

    run_detect #(.RUN_LEN(2), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .inbits(inbits), .in_valid(in_valid), .mode(mode),
        .overlap(overlap), .clear(clear), .detect(c_det), .detect_val(c_val),
        .run_len(c_len), .det_count(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; results are sampled 1ns after the rising edge.
    task automatic step(input logic b, input logic v, input logic clr);
        @(negedge clk);
        inbits   = b;
        in_valid = v;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    int p1_bit[6] = '{1, 1, 1, 0, 0, 1};
    int p1_det[6] = '{0, 1, 1, 0, 1, 0};
    int p1_val[6] = '{0, 1, 1, 1, 0, 0};
    int p1_len[6] = '{1, 2, 2, 1, 2, 1};
    int p1_cnt[6] = '{0, 1, 2, 2, 3, 3};

    int p2_len[7] = '{1, 2, 0, 1, 2, 0, 1};
    int p2_det[7] = '{0, 0, 1, 0, 0, 1, 0};

    int p3_bit[6] = '{0, 0, 0, 1, 1, 1};
    int p3_len[6] = '{1, 2, 3, 1, 2, 3};
    int p3_det[6] = '{0, 0, 0, 0, 0, 1};

    int p5_cnt[6] = '{0, 1, 2, 3, 3, 3};

    initial begin
        reset    = 1'b1;
        inbits   = 1'b0;
        in_valid = 1'b0;
        mode     = 2'b00;
        overlap  = 1'b1;
        clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_detect", 32'(a_det), 0);
        chk("reset_val",    32'(a_val), 0);
        chk("reset_len",    32'(a_len), 0);
        chk("reset_cnt",    32'(a_cnt), 0);
        @(negedge clk);
        reset = 1'b0;

        // Pair-detect behaviour: RUN_LEN=2, mode 00, overlap
        for (int i = 0; i < 6; i++) begin
            step(p1_bit[i][0], 1'b1, 1'b0);
            chk($sformatf("p1_det[%0d]", i), 32'(a_det), p1_det[i]);
            chk($sformatf("p1_val[%0d]", i), 32'(a_val), p1_val[i]);
            chk($sformatf("p1_len[%0d]", i), 32'(a_len), p1_len[i]);
            chk($sformatf("p1_cnt[%0d]", i), 32'(a_cnt), p1_cnt[i]);
        end

        // Non-overlapping zeros on RUN_LEN=3
        overlap = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        chk("p2_clear_len", 32'(b_len), 0);
        chk("p2_clear_cnt", 32'(b_cnt), 0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("p2_len[%0d]", i), 32'(b_len), p2_len[i]);
            chk($sformatf("p2_det[%0d]", i), 32'(b_det), p2_det[i]);
        end
        chk("p2_cnt", 32'(b_cnt), 2);
        chk("p2_val", 32'(b_val), 0);

        // Ones-only filtering on RUN_LEN=3
        overlap = 1'b1;
        mode    = 2'b01;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(p3_bit[i][0], 1'b1, 1'b0);
            chk($sformatf("p3_len[%0d]", i), 32'(b_len), p3_len[i]);
            chk($sformatf("p3_det[%0d]", i), 32'(b_det), p3_det[i]);
        end
        chk("p3_val", 32'(b_val), 1);
        chk("p3_cnt", 32'(b_cnt), 1);

        // Idle gaps do not break a run; clear discards a simultaneous sample
        mode = 2'b00;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("p4_first_det", 32'(a_det), 0);
        chk("p4_first_len", 32'(a_len), 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("p4_idle_det[%0d]", i), 32'(a_det), 0);
            chk($sformatf("p4_idle_len[%0d]", i), 32'(a_len), 1);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("p4_second_det", 32'(a_det), 1);
        chk("p4_second_len", 32'(a_len), 2);
        chk("p4_second_cnt", 32'(a_cnt), 1);
        step(1'b1, 1'b1, 1'b1);
        chk("p4_clr_det", 32'(a_det), 0);
        chk("p4_clr_len", 32'(a_len), 0);
        chk("p4_clr_cnt", 32'(a_cnt), 0);
        chk("p4_clr_val", 32'(a_val), 1);

        // Saturating 2-bit counter, then asynchronous reset mid-stream
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("p5_cnt[%0d]", i), 32'(c_cnt), p5_cnt[i]);
            chk($sformatf("p5_det[%0d]", i), 32'(c_det), (i == 0) ? 0 : 1);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("p5_rst_det", 32'(c_det), 0);
        chk("p5_rst_val", 32'(c_val), 0);
        chk("p5_rst_len", 32'(c_len), 0);
        chk("p5_rst_cnt", 32'(c_cnt), 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk("p5_post_len", 32'(c_len), 1);
        chk("p5_post_det", 32'(c_det), 0);
        chk("p5_post_cnt", 32'(c_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_detect.md
# run_detect

Parametrised serial run detector: samples a one-bit stream under a valid qualifier and pulses `detect` when RUN_LEN consecutive equal bits have been received. It supports value filtering (ones, zeros or either), overlapping or non-overlapping detection, a synchronous clear and a saturating detection counter. It sits on the serial receive path as the generalised successor to the fixed two-bit pair detector; RUN_LEN=2 with mode 00 and overlap=1 gives pair-detect behaviour.

## Interface
- RUN_LEN, 2: run length to detect; legal range 2..255.
- CNT_W, 8: width of `det_count`.
- RL_W, $clog2(RUN_LEN+1): width of `run_len`; derived, not overridden.

- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- inbits  in  1  serial data bit; sampled only when `in_valid`=1.
- in_valid  in  1  sample qualifier.
- mode  in  2  00 either value; 01 ones only; 10 zeros only; 11 detection disabled.
- overlap  in  1  1 = overlapping detection; 0 = run restarts after each detection.
- clear  in  1  synchronous clear of run tracking and counter.
- detect  out  1  one-cycle registered detection pulse.
- detect_val  out  1  bit value of the run that caused the last detection.
- run_len  out  RL_W  current run length, 0..RUN_LEN.
- det_count  out  CNT_W  saturating count of detections.

## Operation
- Internal state:
  - `last_bit`: last accepted bit.
  - `have_last`: set once any bit has been accepted.
  - `run_cnt`: drives `run_len`.
- Priority at each rising edge: clear, then in_valid, then hold.
- `clear`=1:
  - run_cnt=0, have_last=0, det_count=0, detect=0.
  - detect_val holds.
  - Any in_valid sample in the same cycle is discarded.
- `in_valid`=1, clear=0, with sample b:
  - cont = have_last && (b == last_bit).
  - nxt = cont ? min(run_cnt+1, RUN_LEN) : 1.
  - hit = (nxt == RUN_LEN) && mode_ok(b).
  - mode_ok: 00 always true; 01 requires b=1; 10 requires b=0; 11 always false.
  - last_bit ← b, have_last ← 1.
  - run_cnt ← (hit && !overlap) ? 0 : nxt.
  - detect ← hit.
  - If hit: detect_val ← b, and det_count ← det_count+1 unless it is already all-ones (saturates).
- `in_valid`=0, clear=0: all state holds and detect ← 0. Idle cycles do not break a run.
- Overlap=1: once a run reaches RUN_LEN, every further equal valid bit produces a hit (run_cnt holds at RUN_LEN).
- Overlap=0: after a hit, run_cnt=0 and last_bit is kept. An equal bit then gives nxt=1, so a further RUN_LEN equal bits are needed for the next hit.
- A bit filtered out by mode still updates run tracking. Example: mode=01 with a zero-run of RUN_LEN gives no hit, and run_cnt sits at RUN_LEN.
- `mode` and `overlap` are sampled every cycle and may change at any time; no glitch requirement beyond the registered outputs.

## Timing
- Reset (asynchronous assert, takes effect immediately): detect=0, detect_val=0, run_len=0, det_count=0, have_last=0, last_bit=0.
- Reset deassertion is synchronous to clk, owned by the system.
- Latency: a sample accepted at edge k produces detect high in the cycle after edge k, for exactly one cycle unless the sample at edge k+1 also hits.
- det_count, detect_val and run_len update at the same edge as detect.
- Back-to-back valid samples are accepted every cycle; no backpressure.
- Reset asserted mid-run aborts the run immediately; no detect is produced for the partial run.

## Test plan
- RUN_LEN=2, mode=00, overlap=1, valid every cycle, bits 1,1,1,0,0,1 → detect after the 2nd, 3rd and 5th bit; detect_val 1,1,0; det_count=3.
- RUN_LEN=3, overlap=0, bits 0×7 → hits on the 3rd and 6th bit only; run_len after each bit 1,2,0,1,2,0,1.
- RUN_LEN=3, mode=01, bits 0,0,0,1,1,1 → no detect on the zeros (run_len reaches 3); detect on the 6th bit with detect_val=1.
- RUN_LEN=2, bits 1, then in_valid=0 for 5 cycles, then 1 → detect after the second valid bit. Then clear and in_valid=1 with bit 1 in the same cycle → run_len=0, det_count=0, no detect.
- CNT_W=2, continuous ones with overlap=1 → det_count goes 1,2,3 and stays 3. Reset asserted mid-stream → all outputs zero in the same cycle. After release, one 1-bit → run_len=1, no detect.
